// File: rtl/multu_iter.sv
// multu_iter: unsigned WIDTH x WIDTH -> 2*WIDTH iterative shift-add multiplier.
//
// Operands are latched when start is seen in IDLE. The multiply then runs for
// a fixed number of cycles. After that the product appears on z, and done
// pulses for one cycle. z keeps the last product until the next one completes
// or reset is asserted.
//
// Build option: define MULTU_RADIX4_EN to retire two multiplier bits per
// cycle (radix-4). This gives a latency of WIDTH/2+2 instead of WIDTH+2.
// Ports and handshake are the same in both builds.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (0 = reset asserted)
//   start  in   one-cycle pulse that begins a multiply; ignored while busy
//   a      in   WIDTH-bit multiplicand, sampled on the start cycle
//   b      in   WIDTH-bit multiplier, sampled on the start cycle
//   busy   out  high from the start edge until the done cycle ends
//   done   out  one-cycle pulse; z holds the new product in this cycle
//   z      out  2*WIDTH-bit registered product
module multu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int unsigned PW = 2 * WIDTH;
`ifdef MULTU_RADIX4_EN
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned SH    = 2;
`else
    localparam int unsigned STEPS = WIDTH;
    localparam int unsigned SH    = 1;
`endif
    localparam int unsigned CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

`ifdef MULTU_RADIX4_EN
    // 3*mcand is kept in its own register and shifted together with mcand.
    // This keeps the carry-propagating x3 add out of the per-cycle path.
    logic [PW-1:0] mcand3;

    always_comb begin
        addend = '0;
        case (mplier[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = mcand;
            2'd2:    addend = mcand << 1;
            default: addend = mcand3;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        if (mplier[0]) begin
            addend = mcand;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
`ifdef MULTU_RADIX4_EN
            mcand3 <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a_ext;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= CW'(STEPS);
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef MULTU_RADIX4_EN
                        mcand3 <= a_ext + (a_ext << 1);
`endif
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        acc    <= acc + addend;
                        mcand  <= mcand << SH;
                        mplier <= mplier >> SH;
                        cnt    <= cnt - 1'b1;
`ifdef MULTU_RADIX4_EN
                        mcand3 <= mcand3 << SH;
`endif
                    end else begin
                        // Counter exhausted: publish the product. The done
                        // cycle is spent in FINISH with busy still high, so
                        // a start in that cycle is ignored.
                        z     <= acc;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multu_iter.sv
// Directed testbench for multu_iter. Expected products are hand-computed
// constants, except in the back-to-back loop, which uses a 64-bit reference
// product.
module tb_multu_iter;

`ifdef MULTU_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] z;

    int n_checks = 0;
    int n_pass   = 0;

    multu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Issue one multiply and wait for done, with a bound on the wait. If
    // disturb is set, the operands are changed and start is pulsed while the
    // block is busy, and start is also pulsed in the done cycle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [63:0] exp, input string tag, input bit disturb);
        int cyc;
        bit seen;
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy_rise"}, 64'(busy), 64'd1);
            if (disturb && cyc == 3) begin
                a = ~ta;
                b = ~tb_v;
                start = 1'b1;
            end
            if (disturb && cyc == 4) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_z"}, z, exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        if (disturb) begin
            start = 1'b1;                 // sampled while in the done cycle
            @(negedge clk);
            start = 1'b0;
            check({tag, "_done_single"}, 64'(done), 64'd0);
            check({tag, "_idle1"}, 64'(busy), 64'd0);
            @(negedge clk);
            check({tag, "_idle2"}, 64'(busy), 64'd0);
            check({tag, "_z_hold"}, z, exp);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1 check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int dones;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        // Reset held: random activity must not disturb the outputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            start = 1'(($urandom & 1));
            check("rst_hold_z", z, 64'd0);
            check("rst_hold_busy_done", {62'd0, busy, done}, 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {busy, done, z}, 66'd0);
        end
        @(posedge clk);
        #1;

        run_op(32'hE6104084, 32'hE65460A4, 64'hCEFE6E253DEAD490, "main", 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max", 1'b0);
        run_op(32'h00000000, 32'h12345678, 64'h0, "zero_a", 1'b0);
        run_op(32'h00000001, 32'h80000000, 64'h0000000080000000, "one_msb", 1'b0);
        run_op(32'd3, 32'd5, 64'd15, "ignore", 1'b1);
        run_op(32'd7, 32'd6, 64'd42, "second", 1'b0);

        // Reset in the middle of an operation aborts it without a done pulse.
        a = 32'hE6104084;
        b = 32'hE65460A4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1 check("midrst_z", z, 64'd0);
        check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        check("midrst_idle", {busy, z}, 65'd0);
        @(posedge clk);
        #1;
        run_op(32'hE6104084, 32'hE65460A4, 64'hCEFE6E253DEAD490, "after_rst", 1'b0);

        // Back-to-back random operands, each started on the first idle cycle.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 64'(ra) * 64'(rb), "b2b", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multu_iter.md
Name: multu_iter

Overview:
- Unsigned 32x32 -> 64-bit iterative (shift-add) multiplier for the CPU's MULTU instruction; its result feeds the HI/LO registers.
- Operands are latched on a start pulse; the block runs a fixed number of cycles, then presents the product on z with a one-cycle done pulse.
- z holds the last product until the next operation completes or reset is asserted.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- start  in  1  pulse high for one cycle to begin a multiply; ignored while busy=1.
- a  in  WIDTH  multiplicand, unsigned, sampled on the start cycle.
- b  in  WIDTH  multiplier, unsigned, sampled on the start cycle.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when z is updated with a new product.
- z  out  2*WIDTH  unsigned product a*b, registered.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, z=0, internal accumulator/counter cleared. Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FINISH: one cycle, writes z, done=1.
- IDLE -> RUN on a clock edge with start=1. On that edge:
  - latch mcand=a, zero-extended to 2*WIDTH;
  - latch mplier=b;
  - acc=0;
  - cnt=WIDTH.
- RUN, each cycle:
  - if mplier[0]=1, acc += mcand (2*WIDTH-bit add, carries kept);
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - When cnt reaches 0, go to FINISH.
- FINISH: z <= acc; done=1 for exactly this cycle; next state is IDLE.
- Latency, radix-2 build: start sampled at edge N; z valid and done=1 in the cycle after edge N+WIDTH+1 (34 cycles for WIDTH=32). Latency is fixed and independent of operand values.
- start while busy=1 (RUN or FINISH) is ignored, with no queuing. start in the same cycle that done=1 is ignored; the next start is accepted only once busy=0.
- Changing a or b after the start cycle does not affect the operation in flight.
- Arithmetic is unsigned only, with no overflow possible: max 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001 fits in 64 bits.
- Zero operands take the full latency, and z=0.
- z changes only in FINISH or on reset.

Optional Feature:
- Macro: MULTU_RADIX4_EN.
- Defined: radix-4 iteration. Each RUN cycle consumes mplier[1:0]:
  - adds 0, mcand, 2*mcand or 3*mcand to acc;
  - 3*mcand is precomputed into a register on the start edge;
  - then mcand <<= 2, mplier >>= 2, cnt starts at WIDTH/2.
  - Latency becomes WIDTH/2+2 cycles (18). Results are bit-identical to radix-2.
- Undefined: radix-2, as above.
- Ports and handshake are identical in both builds.

Test Plan:
- Reset: hold reset=0 with random a/b and start pulses -> z=0, busy=0, done=0 throughout. Release reset -> outputs stay 0 until a start.
- Main vector: a=0xE6104084, b=0xE65460A4, pulse start -> done pulse after 34 cycles (18 with MULTU_RADIX4_EN), z=0xCEFE6E253DEAD490, busy low afterward.
- Corners, one start each:
  - a=0xFFFFFFFF, b=0xFFFFFFFF -> z=0xFFFFFFFE00000001;
  - a=0, b=0x12345678 -> z=0;
  - a=1, b=0x80000000 -> z=0x0000000080000000.
- Operand change and ignored start: a=3, b=5, start, then change a/b and pulse start while busy -> z=15, exactly one done pulse. A second start after busy=0 with a=7, b=6 -> z=42.
- Reset mid-run: start a=0xE6104084, b=0xE65460A4, assert reset=0 at cycle 10 -> z=0, no done pulse. A new start after release -> correct product.
- Back-to-back: issue start on the first cycle busy=0 after each done, for 1000 random pairs -> each z equals a reference 64-bit unsigned product.
